// File: rtl/md_pkg.sv
// Multiply/divide unit shared definitions:
// op encodings and op-class helpers.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MADD  = 4'd5,
    MD_MADDU = 4'd6,
    MD_MSUB  = 4'd7,
    MD_MSUBU = 4'd8,
    MD_MTHI  = 4'd9,
    MD_MTLO  = 4'd10
  } md_op_e;

  function automatic logic opIsMul(md_op_e op);
    return op inside {MD_MULT, MD_MULTU, MD_MADD,
                      MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction

  function automatic logic opIsDiv(md_op_e op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

  function automatic logic opIsLong(md_op_e op);
    return opIsMul(op) | opIsDiv(op);
  endfunction

  function automatic logic opIsSigned(md_op_e op);
    return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Issue/result bundle between the E stage
// and the multiply/divide unit.
interface e_mdu_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic             i_flush;
  logic [3:0]       i_mdOp;
  logic [WIDTH-1:0] i_srcA;
  logic [WIDTH-1:0] i_srcB;
  logic             o_busy;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_flush, i_mdOp,
    output i_srcA, i_srcB,
    input  o_busy, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_flush, i_mdOp,
    input  i_srcA, i_srcB,
    output o_busy, o_hi, o_lo
  );
endinterface

// File: rtl/e_mdu_calc.sv
// Combinational multiply/divide/accumulate
// datapath producing the full {HI,LO} result.
module e_mdu_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e             op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic [2*WIDTH-1:0] res_o
);

  localparam int W2 = 2 * WIDTH;

  logic signed [W2-1:0]    sa, sb, smul;
  logic [W2-1:0]           umul, prod, div;
  logic                    dz, ovf;
  logic [WIDTH-1:0]        bs, bu, uq, ur;
  logic signed [WIDTH-1:0] sq, sr;

  assign sa   = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign sb   = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign smul = sa * sb;
  assign umul = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  assign dz  = (b_i == '0);
  assign ovf = (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);

  // Overflow divides by +1 instead: that yields MIN / 0 directly.
  assign bs = (dz | ovf) ? WIDTH'(1) : b_i;
  assign bu = dz ? WIDTH'(1) : b_i;
  assign sq = $signed(a_i) / $signed(bs);
  assign sr = $signed(a_i) % $signed(bs);
  assign uq = a_i / bu;
  assign ur = a_i % bu;

  always_comb begin
    prod = opIsSigned(op_i) ? smul : umul;
    if (dz)
      div = {a_i, {WIDTH{1'b1}}};
    else if (opIsSigned(op_i))
      div = {sr, sq};
    else
      div = {ur, uq};
  end

  always_comb begin
    res_o = prod;
    unique case (1'b1)
      opIsDiv(op_i):
        res_o = div;
      (op_i == MD_MADD) || (op_i == MD_MADDU):
        res_o = acc_i + prod;
      (op_i == MD_MSUB) || (op_i == MD_MSUBU):
        res_o = acc_i - prod;
      default:
        res_o = prod;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multi-cycle multiply/divide unit
// with HI/LO accumulators and busy interlock.
module e_mdu
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  e_mdu_if.slave  md
);

  localparam int MAXC =
    (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] pend_q;
  logic [2*WIDTH-1:0] res;
  md_op_e             op;
  logic               accept;

  assign op     = md_op_e'(md.i_mdOp);
  assign accept = md.i_start & ~md.i_flush & (state_q == IDLE);

  e_mdu_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .op_i  (op),
    .a_i   (md.i_srcA),
    .b_i   (md.i_srcB),
    .acc_i ({hi_q, lo_q}),
    .res_o (res)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          if (op == MD_MTHI) hi_q <= md.i_srcA;
          if (op == MD_MTLO) lo_q <= md.i_srcA;
          if (opIsLong(op)) begin
            pend_q  <= res;
            cnt_q   <= opIsDiv(op) ? CW'(DIV_CYCLES)
                                   : CW'(MUL_CYCLES);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            {hi_q, lo_q} <= pend_q;
            state_q      <= IDLE;
          end
        end
      endcase
    end
  end

  assign md.o_busy = (state_q == BUSY);
  assign md.o_hi   = hi_q;
  assign md.o_lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: random ops against
// an arithmetic reference model of HI/LO.
module tb_e_mdu;
  import md_pkg::*;

  localparam int MULC = 5;
  localparam int DIVC = 10;

  typedef struct {
    int          e0;
    int          td;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_done = 0;
  logic [31:0] mhi = '0, mlo = '0;
  exp_t q[$];

  e_mdu_if #(.WIDTH(32)) bus ();

  e_mdu #(
    .WIDTH      (32),
    .MUL_CYCLES (MULC),
    .DIV_CYCLES (DIVC)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .md      (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, req);
    end
  endtask

  // Reference: apply one accepted op to the HI/LO model.
  task automatic model(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output int n);
    logic [63:0] acc, sp, up, r;
    int sa, sb, qq, rr;
    acc = {mhi, mlo};
    sp  = 64'(longint'($signed(a)) * longint'($signed(b)));
    up  = {32'b0, a} * {32'b0, b};
    sa  = $signed(a);
    sb  = $signed(b);
    n   = 0;
    r   = acc;
    case (op)
      MD_MULT:  begin n = MULC; r = sp; end
      MD_MULTU: begin n = MULC; r = up; end
      MD_MADD:  begin n = MULC; r = acc + sp; end
      MD_MADDU: begin n = MULC; r = acc + up; end
      MD_MSUB:  begin n = MULC; r = acc - sp; end
      MD_MSUBU: begin n = MULC; r = acc - up; end
      MD_DIV: begin
        n = DIVC;
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          r = {32'h0, 32'h8000_0000};
        else begin
          qq = sa / sb;
          rr = sa - qq * sb;
          r  = {32'(rr), 32'(qq)};
        end
      end
      MD_DIVU: begin
        n = DIVC;
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      MD_MTHI: r = {a, mlo};
      MD_MTLO: r = {mhi, a};
      default: r = acc;
    endcase
    {mhi, mlo} = r;
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input bit fl);
    exp_t e;
    int n;
    @(negedge clk);
    while (cyc < last_done) @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_flush = fl;
    bus.i_mdOp  = op;
    bus.i_srcA  = a;
    bus.i_srcB  = b;
    e.e0 = cyc + 1;
    if (fl) n = 0;
    else model(op, a, b, n);
    e.td = e.e0 + n;
    e.hi = mhi;
    e.lo = mlo;
    q.push_back(e);
    last_done = e.td;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
  endtask

  // Start pulse the DUT must ignore (busy or flushed-while-busy).
  task automatic poke(input logic [3:0] op, input bit fl);
    bus.i_start = 1'b1;
    bus.i_flush = fl;
    bus.i_mdOp  = op;
    bus.i_srcA  = $urandom;
    bus.i_srcB  = $urandom;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && q.size() > 0) begin
      e = q[0];
      if (cyc > e.e0 && cyc < e.td)
        chk("busy_high", 32'(bus.o_busy), 32'd1);
      else if (cyc == e.td) begin
        void'(q.pop_front());
        chk("busy_low", 32'(bus.o_busy), 32'd0);
        chk("hi", bus.o_hi, e.hi);
        chk("lo", bus.o_lo, e.lo);
      end else if (cyc > e.td) begin
        void'(q.pop_front());
        chk("late_result", 32'(cyc), 32'(e.td));
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_mdOp  = '0;
    bus.i_srcA  = '0;
    bus.i_srcB  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_hi", bus.o_hi, 32'd0);
    chk("rst_lo", bus.o_lo, 32'd0);
    rst_n = 1'b1;
    last_done = cyc;

    issue(MD_MULT,  32'hFFFF_FFFD, 32'd5, 0);
    issue(MD_MULTU, 32'hFFFF_FFFD, 32'd5, 0);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd2, 0);
    issue(MD_DIVU,  32'd7, 32'd2, 0);
    issue(MD_DIVU,  32'h1234, 32'd0, 0);
    issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(MD_DIV,   32'h55, 32'd0, 0);
    issue(MD_MTHI,  32'd1, 32'd0, 0);
    issue(MD_MTLO,  32'd2, 32'd0, 0);
    issue(MD_MADD,  32'd3, 32'd4, 0);
    issue(MD_MSUBU, 32'hF, 32'd1, 0);
    issue(MD_MULT,  32'h1111, 32'h2222, 1);
    issue(MD_NONE,  32'hDEAD, 32'hBEEF, 0);

    // Ignored starts and flush during a busy MULT.
    issue(MD_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    poke(MD_MTHI, 0);
    poke(MD_DIV, 1);
    poke(MD_MULTU, 0);

    // Async reset in the third busy cycle of a DIV.
    issue(MD_DIV, 32'd1000, 32'd7, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_busy", 32'(bus.o_busy), 32'd0);
    chk("arst_hi", bus.o_hi, 32'd0);
    chk("arst_lo", bus.o_lo, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mhi = '0;
    mlo = '0;
    last_done = cyc;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", 32'(bus.o_busy), 32'd0);
    chk("post_rst_hi", bus.o_hi, 32'd0);
    chk("post_rst_lo", bus.o_lo, 32'd0);

    for (int i = 0; i < 250; i++) begin
      op = 4'($urandom_range(0, 10));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = '1; end
        2: begin a = 32'($urandom_range(0, 99));
                 b = 32'($urandom_range(1, 9)); end
        3: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(op, a, b, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 5) == 0 && last_done > cyc + 1)
        poke(4'($urandom_range(1, 10)), 1'($urandom));
    end

    for (int i = 0; i < 50 && q.size() > 0; i++)
      @(negedge clk);
    if (q.size() > 0)
      chk("drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
